// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared tile geometry, overlay select codes and colour packing
package tile_pkg;

  localparam int tile_size = 16;

  localparam logic [2:0] MSEL_NONE      = 3'd0;
  localparam logic [2:0] MSEL_DOT       = 3'd1;
  localparam logic [2:0] MSEL_BIG_DOT   = 3'd2;
  localparam logic [2:0] MSEL_PLAYER_F1 = 3'd3;
  localparam logic [2:0] MSEL_PLAYER_F2 = 3'd4;
  localparam logic [2:0] MSEL_GHOST_F1  = 3'd5;
  localparam logic [2:0] MSEL_GHOST_F2  = 3'd6;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // Colours travel as {r,g,b}, one nibble each.
  function automatic logic [11:0] pack_rgb(input logic [3:0] r, input logic [3:0] g,
                                           input logic [3:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/tile_pixel_counter.sv
// rtl/tile_pixel_counter.sv - row-major row/col scan counter for one tile
import tile_pkg::*;

module tile_pixel_counter #(
  parameter int TILE = tile_size
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      advance,
  output logic [$clog2(TILE)-1:0]   row,
  output logic [$clog2(TILE)-1:0]   col,
  output logic                      last
);

  localparam int RW = $clog2(TILE);
  localparam logic [RW-1:0] MAX = RW'(TILE - 1);

  // Advancing past the last pixel wraps both counters back to the origin.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == MAX) begin
        col <= '0;
        row <= (row == MAX) ? '0 : row + RW'(1);
      end else begin
        col <= col + RW'(1);
      end
    end
  end

  assign last = (row == MAX) && (col == MAX);

endmodule

// File: rtl/tile_pixel_streamer.sv
// rtl/tile_pixel_streamer.sv - composes one tile from base colour and overlay mask and streams it
import tile_pkg::*;

module tile_pixel_streamer #(
  parameter int TILE  = tile_size,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [TILE*TILE*4-1:0]      background_r,
  input  logic [TILE*TILE*4-1:0]      background_g,
  input  logic [TILE*TILE*4-1:0]      background_b,
  input  logic [TILE*TILE*4-1:0]      wall_r,
  input  logic [TILE*TILE*4-1:0]      wall_g,
  input  logic [TILE*TILE*4-1:0]      wall_b,
  input  logic [TILE*TILE-1:0]        dot_mask,
  input  logic [TILE*TILE-1:0]        big_dot_mask,
  input  logic [TILE*TILE-1:0]        player_mask_f1,
  input  logic [TILE*TILE-1:0]        player_mask_f2,
  input  logic [TILE*TILE-1:0]        ghost_mask_f1,
  input  logic [TILE*TILE-1:0]        ghost_mask_f2,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_wall,
  input  logic [2:0]                  req_mask_sel,
  input  logic [11:0]                 req_color,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic [11:0]                 pix_rgb,
  output logic [$clog2(TILE)-1:0]     pix_row,
  output logic [$clog2(TILE)-1:0]     pix_col,
  output logic                        pix_last,
  output logic [CNT_W-1:0]            tiles_done
);

  localparam int NPIX = TILE * TILE;
  localparam int PW   = $clog2(NPIX);

  state_t            state, state_next;
  logic              accept, handshake;
  logic [NPIX-1:0]   mask_pick, mask_reg;
  logic              wall_reg;
  logic [11:0]       color_reg;
  logic [PW-1:0]     pix_idx;
  logic [11:0]       base_rgb;

  tile_pixel_counter #(.TILE(TILE)) u_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .advance (handshake),
    .row     (pix_row),
    .col     (pix_col),
    .last    (pix_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    pix_valid  = 1'b0;
    accept     = 1'b0;
    handshake  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        pix_valid = 1'b1;
        if (pix_ready) begin
          handshake = 1'b1;
          if (pix_last) state_next = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    mask_pick = '0;
    case (req_mask_sel)
      MSEL_DOT:       mask_pick = dot_mask;
      MSEL_BIG_DOT:   mask_pick = big_dot_mask;
      MSEL_PLAYER_F1: mask_pick = player_mask_f1;
      MSEL_PLAYER_F2: mask_pick = player_mask_f2;
      MSEL_GHOST_F1:  mask_pick = ghost_mask_f1;
      MSEL_GHOST_F2:  mask_pick = ghost_mask_f2;
      default:        mask_pick = '0;
    endcase
  end

  // The mask is frozen at accept so loader updates cannot tear a tile in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_reg  <= '0;
      wall_reg  <= 1'b0;
      color_reg <= '0;
    end else if (accept) begin
      mask_reg  <= mask_pick;
      wall_reg  <= req_wall;
      color_reg <= req_color;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                        tiles_done <= '0;
    else if (handshake && pix_last) tiles_done <= tiles_done + CNT_W'(1);
  end

  assign pix_idx = PW'(int'(pix_row) * TILE + int'(pix_col));

  always_comb begin
    if (wall_reg)
      base_rgb = pack_rgb(wall_r[4*pix_idx +: 4], wall_g[4*pix_idx +: 4], wall_b[4*pix_idx +: 4]);
    else
      base_rgb = pack_rgb(background_r[4*pix_idx +: 4], background_g[4*pix_idx +: 4],
                          background_b[4*pix_idx +: 4]);
  end

  assign pix_rgb = (state != ST_RUN) ? 12'h000 : (mask_reg[pix_idx] ? color_reg : base_rgb);

endmodule
